dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single A-port of the synchronous data RAM between two requesters: the CPU memory stage (port 0) and the debug/loader engine (port 1).
- Arbitrates requests each cycle, performs sub-word store lane steering (byte/half/word), tags the response, and returns read data one cycle after grant.
- Generates back-pressure so the pipeline stalls (drives the segment-register en low) while the CPU is not granted.

Parameters:
- ADDR_W, 32, byte-address width of both requesters.
- WAIT_MAX, 8, consecutive lost-arbitration cycles after which port 1 is forced to win (starvation guard).
- CNT_W, 4, width of the starvation counter; must hold WAIT_MAX.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  CPU request accepted this cycle
- cpu_req_addr  in  ADDR_W  byte address
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- cpu_req_wdata  in  32  store data, right-aligned
- cpu_rsp_valid  out  1  read data valid (cycle after load grant)
- cpu_rsp_rdata  out  32  raw RAM word
- cpu_rsp_err  out  1  misaligned or size=11 request was dropped
- dbg_req_valid, dbg_req_ready, dbg_req_addr, dbg_req_we, dbg_req_size, dbg_req_wdata, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err  same widths and meanings, port 1
- ram_wea  out  4  byte write enables to RAM
- ram_addr  out  ADDR_W-2  word address (addr[ADDR_W-1:2])
- ram_din  out  32  lane-steered write data
- ram_dout  in  32  RAM read data (valid one cycle after address)
- cpu_stall  out  1  cpu_req_valid && !cpu_req_ready

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Reset: all outputs 0. Internal state is rsp_owner = NONE, starvation counter = 0, last_winner = port 1.
- Grant, default fixed priority: CPU wins.
  - Exception: if the starvation counter == WAIT_MAX and dbg_req_valid, debug wins.
  - Exactly one ready is high per cycle, and only when that port's valid is high.
- Starvation counter:
  - Increments (saturating at WAIT_MAX) each cycle dbg_req_valid && !dbg_req_ready.
  - Clears on a debug grant or when dbg_req_valid is low.
- RAM drive: combinational from the granted request in the grant cycle T. With no grant: ram_wea = 0, ram_addr holds its previous value (registered copy), ram_din = 0.
- Lane steering, word (size 10):
  - wea = 1111, din = wdata; addr[1:0] must be 00.
- Lane steering, half (size 01):
  - wea = 0011 << (2*addr[1]); din = wdata[15:0] replicated into the selected half.
  - addr[0] must be 0.
- Lane steering, byte (size 00):
  - wea = 0001 << addr[1:0]; din = wdata[7:0] shifted into the selected lane.
- Loads: wea = 0000.
- Misaligned or size 11:
  - Request is still accepted (ready = 1) but the RAM is not driven (wea = 0).
  - The port's rsp_err pulses for 1 cycle at T+1; rsp_valid stays 0.
- Response timing:
  - A granted load at T sets rsp_owner so the owner's rsp_valid = 1 at T+1, with rsp_rdata = ram_dout.
  - Stores produce no rsp_valid.
  - Back-to-back grants to either port are allowed every cycle; there are no bubbles.
- Responses are never lost: a grant to port X at T+1 does not disturb the response of the T grant.
- rsp_rdata of a non-owner port reads 0.
- Reset mid-transaction: an outstanding response is discarded and rsp_valid does not assert after reset release.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous valids, the port other than last_winner wins. last_winner updates on every grant. The starvation counter is still implemented but can never reach WAIT_MAX.
- Undefined: fixed CPU priority with the starvation guard, as described above.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - owner encoding OWN_NONE/OWN_CPU/OWN_DBG;
  - port index constants.
- One natural sub-module: dmem_lane_steer. Combinational: size, addr[1:0], we, wdata in; wea, din, misalign out. Instantiated once, after the grant mux.

Test Plan:
- CPU sw to 0x0000_0010 with wdata 0xDEADBEEF, then lw same address → ram_wea = 1111, ram_addr = 0x4; cpu_rsp_valid at T+1 with rdata 0xDEADBEEF.
- CPU sb 0xAB to 0x13, then sh 0x1234 to 0x16 → wea 1000, din 0xAB000000; wea 1100, din 0x12341234.
- CPU sh to 0x11 (misaligned) → cpu_req_ready = 1, ram_wea = 0, cpu_rsp_err pulses at T+1, RAM contents unchanged.
- Both ports valid continuously, fixed priority, WAIT_MAX = 8 → CPU granted 8 cycles, debug granted on cycle 9 with cpu_stall = 1 that cycle, then the pattern repeats.
- Same stimulus with DMEM_ARB_RR_EN defined → grants alternate CPU, DBG, CPU, …; each load response is routed to the correct port at T+1.
- rst asserted in the cycle after a debug load grant → dbg_rsp_valid never asserts and all outputs read 0 asynchronously.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory port arbiter (access sizes, response owner, port indices).
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;
endpackage

// File: rtl/dmem_lane_steer.sv
// dmem_lane_steer: maps a right-aligned store onto RAM byte lanes and flags misaligned/reserved sizes.
module dmem_lane_steer
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  wea,
  output logic [31:0] din,
  output logic        misalign
);
  logic [3:0]  mask;
  logic [31:0] data;
  always_comb begin
    misalign = size == SZ_WORD ? addr != 2'b00 : size == SZ_HALF ? addr[0] : size != SZ_BYTE;
    mask = size == SZ_WORD ? 4'b1111 : size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr;
    data = size == SZ_WORD ? wdata : size == SZ_HALF ? {2{wdata[15:0]}} : {24'd0, wdata[7:0]} << {addr, 3'b000};
    wea = we && !misalign ? mask : 4'b0000;
    din = we && !misalign ? data : 32'd0;
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data RAM A-port between the CPU (port 0) and debug engine (port 1).
// Fixed CPU priority with a starvation guard by default; define DMEM_ARB_RR_EN for round-robin.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              cpu_req_we,
  input  logic [1:0]        cpu_req_size,
  input  logic [31:0]       cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [31:0]       cpu_rsp_rdata,
  output logic              cpu_rsp_err,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic              dbg_req_we,
  input  logic [1:0]        dbg_req_size,
  input  logic [31:0]       dbg_req_wdata,
  output logic              dbg_rsp_valid,
  output logic [31:0]       dbg_rsp_rdata,
  output logic              dbg_rsp_err,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              cpu_stall
);
  logic              gnt_cpu, gnt_dbg, any, drv, we, mis;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [31:0]       wdata, din;
  logic [3:0]        wea;
  logic [ADDR_W-3:0] addr_q;
  logic [CNT_W-1:0]  cnt;
  owner_t            owner;
`ifdef DMEM_ARB_RR_EN
  logic              last_winner;
`endif
  // grants are masked during reset so every output reads 0 while rst is high
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    gnt_dbg = !rst && dbg_req_valid && (!cpu_req_valid || last_winner == PORT_CPU);
`else
    gnt_dbg = !rst && dbg_req_valid && (!cpu_req_valid || cnt == CNT_W'(WAIT_MAX));
`endif
    gnt_cpu = !rst && cpu_req_valid && !gnt_dbg;
    any = gnt_cpu || gnt_dbg;
    addr = gnt_dbg ? dbg_req_addr : cpu_req_addr;
    size = gnt_dbg ? dbg_req_size : cpu_req_size;
    we = gnt_dbg ? dbg_req_we : cpu_req_we;
    wdata = gnt_dbg ? dbg_req_wdata : cpu_req_wdata;
  end
  dmem_lane_steer u_steer (
    .size(size), .addr(addr[1:0]), .we(we), .wdata(wdata),
    .wea(wea), .din(din), .misalign(mis)
  );
  // a dropped (misaligned/reserved) request leaves the RAM untouched, address included
  always_comb begin
    drv = any && !mis;
    ram_wea = drv ? wea : 4'b0000;
    ram_din = drv ? din : 32'd0;
    ram_addr = drv ? addr[ADDR_W-1:2] : addr_q;
    cpu_req_ready = gnt_cpu;
    dbg_req_ready = gnt_dbg;
    cpu_stall = !rst && cpu_req_valid && !gnt_cpu;
    cpu_rsp_valid = owner == OWN_CPU;
    dbg_rsp_valid = owner == OWN_DBG;
    cpu_rsp_rdata = cpu_rsp_valid ? ram_dout : 32'd0;
    dbg_rsp_rdata = dbg_rsp_valid ? ram_dout : 32'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= '0;
      owner <= OWN_NONE;
      cnt <= '0;
      cpu_rsp_err <= 1'b0;
      dbg_rsp_err <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_winner <= PORT_DBG;
`endif
    end else begin
      if (drv) addr_q <= addr[ADDR_W-1:2];
      owner <= drv && !we ? (gnt_dbg ? OWN_DBG : OWN_CPU) : OWN_NONE;
      cpu_rsp_err <= gnt_cpu && mis;
      dbg_rsp_err <= gnt_dbg && mis;
      cnt <= !dbg_req_valid || gnt_dbg ? '0 : cnt == CNT_W'(WAIT_MAX) ? cnt : cnt + 1'b1;
`ifdef DMEM_ARB_RR_EN
      if (any) last_winner <= gnt_dbg ? PORT_DBG : PORT_CPU;
`endif
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus with a per-cycle behavioural model plus hand-computed pins.
module tb_dmem_port_arbiter;
  localparam int WAIT_MAX = 8;
  logic        clk = 1'b0, rst;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_rsp_valid, cpu_rsp_err;
  logic [31:0] cpu_req_addr, cpu_req_wdata, cpu_rsp_rdata;
  logic [1:0]  cpu_req_size;
  logic        dbg_req_valid, dbg_req_ready, dbg_req_we, dbg_rsp_valid, dbg_rsp_err;
  logic [31:0] dbg_req_addr, dbg_req_wdata, dbg_rsp_rdata;
  logic [1:0]  dbg_req_size;
  logic [3:0]  ram_wea;
  logic [29:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 32'd0;
  logic        cpu_stall;
  logic [31:0] mem [64];
  logic [31:0] mdl [64];
  int passed = 0, total = 0;
  int m_wait = 0, m_own = 0;
  logic m_last = 1'b1, m_ec = 1'b0, m_ed = 1'b0;
  logic [31:0] m_rd = 32'd0;
  logic [29:0] m_addr = 30'd0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .cpu_req_we(cpu_req_we), .cpu_req_size(cpu_req_size), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_addr(dbg_req_addr),
    .dbg_req_we(dbg_req_we), .dbg_req_size(dbg_req_size), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
    .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .cpu_stall(cpu_stall)
  );

  // synchronous read-first RAM attached to the DUT
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr[5:0]];
    for (int i = 0; i < 4; i++)
      if (ram_wea[i]) mem[ram_addr[5:0]][8*i +: 8] <= ram_din[8*i +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  // reference model: arbitration rules, lane arithmetic, response tagging, model memory
  always @(negedge clk) begin
    logic gd, gc, bad, drv, we;
    logic [31:0] a, wd, ed;
    logic [1:0] sz;
    logic [3:0] ew;
    logic [29:0] ea;
`ifdef DMEM_ARB_RR_EN
    gd = !rst && dbg_req_valid && (!cpu_req_valid || m_last == 1'b0);
`else
    gd = !rst && dbg_req_valid && (!cpu_req_valid || m_wait >= WAIT_MAX);
`endif
    gc = !rst && cpu_req_valid && !gd;
    a = gd ? dbg_req_addr : cpu_req_addr;
    wd = gd ? dbg_req_wdata : cpu_req_wdata;
    sz = gd ? dbg_req_size : cpu_req_size;
    we = gd ? dbg_req_we : cpu_req_we;
    bad = sz == 2'd3 || (sz == 2'd2 && a[1:0] != 2'd0) || (sz == 2'd1 && a[0]);
    drv = (gd || gc) && !bad;
    ew = !drv || !we ? 4'h0 : sz == 2'd2 ? 4'hF : sz == 2'd1 ? 4'(3 << (2 * a[1])) : 4'(1 << a[1:0]);
    ed = ew == 4'h0 ? 32'd0 : sz == 2'd2 ? wd : sz == 2'd1 ? wd[15:0] * 32'h00010001 : 32'(wd[7:0]) << (8 * a[1:0]);
    ea = drv ? a[31:2] : (rst ? 30'd0 : m_addr);
    chk("cpu_req_ready", 32'(cpu_req_ready), 32'(gc));
    chk("dbg_req_ready", 32'(dbg_req_ready), 32'(gd));
    chk("cpu_stall", 32'(cpu_stall), 32'(!rst && cpu_req_valid && !gc));
    chk("ram_wea", 32'(ram_wea), 32'(ew));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    if (ew != 4'h0 || !(gd || gc)) chk("ram_din", ram_din, ed);
    chk("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(!rst && m_own == 1));
    chk("dbg_rsp_valid", 32'(dbg_rsp_valid), 32'(!rst && m_own == 2));
    chk("cpu_rsp_rdata", cpu_rsp_rdata, !rst && m_own == 1 ? m_rd : 32'd0);
    chk("dbg_rsp_rdata", dbg_rsp_rdata, !rst && m_own == 2 ? m_rd : 32'd0);
    chk("cpu_rsp_err", 32'(cpu_rsp_err), 32'(!rst && m_ec));
    chk("dbg_rsp_err", 32'(dbg_rsp_err), 32'(!rst && m_ed));
    if (rst) begin
      m_own = 0; m_ec = 1'b0; m_ed = 1'b0; m_wait = 0; m_last = 1'b1; m_addr = 30'd0;
    end else begin
      m_own = drv && !we ? (gd ? 2 : 1) : 0;
      m_rd = mdl[a[7:2]];
      m_ec = gc && bad;
      m_ed = gd && bad;
      if (drv) m_addr = a[31:2];
      for (int i = 0; i < 4; i++)
        if (ew[i]) mdl[a[7:2]][8*i +: 8] = ed[8*i +: 8];
      m_wait = dbg_req_valid && !gd ? (m_wait < WAIT_MAX ? m_wait + 1 : WAIT_MAX) : 0;
      if (gd || gc) m_last = gd;
    end
  end

  task automatic idle();
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_size = 2'd0; cpu_req_addr = 32'd0; cpu_req_wdata = 32'd0;
    dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_req_size = 2'd0; dbg_req_addr = 32'd0; dbg_req_wdata = 32'd0;
  endtask
  task automatic cpu(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_size = sz; cpu_req_addr = a; cpu_req_wdata = wd;
  endtask
  task automatic dbg(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    dbg_req_valid = 1'b1; dbg_req_we = we; dbg_req_size = sz; dbg_req_addr = a; dbg_req_wdata = wd;
  endtask
  task automatic settle(); @(negedge clk); #1; endtask
  task automatic adv(); @(posedge clk); #1; endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = 32'd0; mdl[i] = 32'd0; end
    idle();
    rst = 1'b0;
    #1 rst = 1'b1;
    settle();
    chk("reset ready", 32'(cpu_req_ready), 32'd0);
    chk("reset wea", 32'(ram_wea), 32'd0);
    chk("reset addr", 32'(ram_addr), 32'd0);
    adv(); rst = 1'b0;
    cpu(1'b1, 2'b10, 32'h10, 32'hDEADBEEF); settle();
    chk("sw wea", 32'(ram_wea), 32'hF);
    chk("sw addr", 32'(ram_addr), 32'h4);
    chk("sw din", ram_din, 32'hDEADBEEF);
    adv(); cpu(1'b0, 2'b10, 32'h10, 32'd0); settle();
    chk("lw wea", 32'(ram_wea), 32'h0);
    adv(); cpu(1'b1, 2'b00, 32'h13, 32'hAB); settle();
    chk("lw rsp valid", 32'(cpu_rsp_valid), 32'd1);
    chk("lw rsp rdata", cpu_rsp_rdata, 32'hDEADBEEF);
    chk("sb wea", 32'(ram_wea), 32'h8);
    chk("sb din", ram_din, 32'hAB000000);
    adv(); cpu(1'b1, 2'b01, 32'h16, 32'h1234); settle();
    chk("sh wea", 32'(ram_wea), 32'hC);
    chk("sh din", ram_din, 32'h12341234);
    adv(); cpu(1'b1, 2'b01, 32'h11, 32'h5555); settle();
    chk("misalign ready", 32'(cpu_req_ready), 32'd1);
    chk("misalign wea", 32'(ram_wea), 32'h0);
    adv(); cpu(1'b0, 2'b10, 32'h10, 32'd0); settle();
    chk("misalign err", 32'(cpu_rsp_err), 32'd1);
    chk("misalign no valid", 32'(cpu_rsp_valid), 32'd0);
    adv(); idle(); settle();
    chk("merged word", cpu_rsp_rdata, 32'hABADBEEF);
    adv(); dbg(1'b1, 2'b10, 32'h20, 32'h55667788); settle();
    chk("dbg sw ready", 32'(dbg_req_ready), 32'd1);
    adv(); cpu(1'b0, 2'b10, 32'h10, 32'd0); dbg(1'b0, 2'b10, 32'h20, 32'd0); settle();
    chk("both cpu wins", 32'(cpu_req_ready), 32'd1);
    chk("both dbg waits", 32'(dbg_req_ready), 32'd0);
    adv(); cpu_req_valid = 1'b0; settle();
    chk("dbg lw ready", 32'(dbg_req_ready), 32'd1);
    adv(); idle(); dbg(1'b1, 2'b11, 32'h24, 32'h1); settle();
    chk("dbg rsp rdata", dbg_rsp_rdata, 32'h55667788);
    chk("dbg rsp cpu zero", cpu_rsp_rdata, 32'd0);
    chk("size11 wea", 32'(ram_wea), 32'h0);
    adv(); idle(); settle();
    chk("size11 err", 32'(dbg_rsp_err), 32'd1);
    adv();
    cpu(1'b0, 2'b10, 32'h10, 32'd0); dbg(1'b0, 2'b10, 32'h20, 32'd0);
    for (int i = 0; i < 18; i++) begin
      logic exp_d;
`ifdef DMEM_ARB_RR_EN
      exp_d = i % 2 == 1;
`else
      exp_d = i % 9 == 8;
`endif
      settle();
      chk("pattern dbg grant", 32'(dbg_req_ready), 32'(exp_d));
      chk("pattern stall", 32'(cpu_stall), 32'(exp_d));
      adv();
    end
    idle(); settle(); adv();
    dbg(1'b0, 2'b10, 32'h20, 32'd0); settle();
    chk("pre-reset dbg grant", 32'(dbg_req_ready), 32'd1);
    adv(); idle(); rst = 1'b1; #1;
    chk("async rst dbg valid", 32'(dbg_rsp_valid), 32'd0);
    chk("async rst dbg rdata", dbg_rsp_rdata, 32'd0);
    chk("async rst addr", 32'(ram_addr), 32'd0);
    cpu(1'b1, 2'b10, 32'h30, 32'h1); #1;
    chk("rst ready", 32'(cpu_req_ready), 32'd0);
    chk("rst stall", 32'(cpu_stall), 32'd0);
    chk("rst wea", 32'(ram_wea), 32'd0);
    settle(); adv(); rst = 1'b0; idle();
    repeat (3) begin
      settle();
      chk("post-reset dbg valid", 32'(dbg_rsp_valid), 32'd0);
      adv();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
